// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package rv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_queue.sv
// In-order instruction buffer; flush drops every entry in one cycle.
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  push_data_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(QDEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  // A pop in the same cycle frees the slot, so push-on-full is accepted then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues credit-limited word fetches,
// buffers responses for decode and discards stale responses after a redirect.
module imem_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] qcount;
  logic          redir, issue_ok, issue, retire, discard;
  logic          q_push, q_pop, q_empty, q_full;
  fetch_entry_t  q_head;

  assign redir    = redirect_valid & (state_q != BOOT);
  assign issue_ok = (state_q == RUN) || ((state_q == FLUSH) && (drop_q == '0));

  // Credit check: every in-flight request already owns a queue slot.
  assign mem_req  = issue_ok & ~redirect_valid &
                    (({1'b0, outst_q} + {1'b0, qcount}) < (CW + 1)'(QDEPTH));
  assign mem_addr = fetch_pc_q;

  assign issue   = mem_req & mem_gnt;
  assign retire  = mem_rvalid & (outst_q != '0);
  assign discard = retire & (drop_q != '0);
  assign q_push  = retire & ~discard & ~redir;

  assign if_valid = ~q_empty & ~redirect_valid;
  assign q_pop    = if_valid & ~id_stall;
  assign if_pc    = if_valid ? q_head.pc : resp_pc_q;
  assign if_instr = if_valid ? q_head.instr : NOP_INSTR;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redir),
    .push_i      (q_push),
    .pop_i       (q_pop),
    .push_data_i ('{pc: resp_pc_q, instr: mem_rdata}),
    .head_o      (q_head),
    .count_o     (qcount),
    .empty_o     (q_empty),
    .full_o      (q_full)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(issue) - CW'(retire);
    drop_d     = drop_q;
    if (discard) drop_d = drop_q - CW'(1);
    if (issue)   fetch_pc_d = fetch_pc_q + 32'd4;
    if (q_push)  resp_pc_d = resp_pc_q + 32'd4;
    case (state_q)
      BOOT:    state_d = RUN;
      FLUSH:   if (drop_q == '0) state_d = RUN;
      default: ;
    endcase
    // Everything still in flight belongs to the old stream; mem_req is low now.
    if (redir) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      drop_d     = outst_q - CW'(retire);
      state_d    = (drop_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mem_rvalid) assert (outst_q != '0);
      assert (!(q_push && q_full && !q_pop));
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench: in-order memory model, expected decode stream queue, monitor.
module tb_imem_fetch_ctrl;

  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.RESET_PC(RPC), .QDEPTH(QD), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] exp_q[$];
  logic [31:0] next_push_pc = RPC;
  int cyc = 0, lat = 1, gnt_pct = 100, last_ready = 0, drv_since = 0;
  int first_valid = -1, delivered = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the memory model's bookkeeping.
  task automatic step(input logic r, input logic rd, input logic [31:0] tgt, input logic st);
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    redirect_valid = rd;
    redirect_pc = tgt;
    id_stall = st;
    if (r) begin
      memq.delete();
      exp_q.delete();
      next_push_pc = RPC;
      last_ready = cyc;
      drv_since = 0;
    end else begin
      drv_since++;
      if (rd) begin
        exp_q.delete();
        next_push_pc = align(tgt);
      end
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_push_pc);
      next_push_pc += 32'd4;
    end
    mem_gnt = !r && ($urandom_range(99) < gnt_pct);
    if (!r && memq.size() > 0 && memq[0].ready <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(memq[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    @(negedge clk);
    if (mem_rvalid) void'(memq.pop_front());
    if (!rst && mem_req && mem_gnt) begin
      int rdy;
      rdy = cyc + lat;
      if (rdy <= last_ready) rdy = last_ready + 1;
      memq.push_back('{addr: mem_addr, ready: rdy});
      last_ready = rdy;
    end
    if (!rst) chk("credit", 32'(memq.size() <= QD), 32'd1);
  endtask

  // Monitor: checks every cycle at the falling edge.
  logic        prev_rst = 1'b0, pend = 1'b0, armed = 1'b0;
  logic [31:0] pend_addr = '0, exp_issue = RPC, epc;
  int          since = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) since = -1;
      else since++;
      if (armed && prev_rst) begin
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_if_pc", if_pc, RPC);
      end
      if (armed && !rst) begin
        if (redirect_valid) begin
          chk("redir_mem_req", 32'(mem_req), 32'd0);
          chk("redir_if_valid", 32'(if_valid), 32'd0);
        end
        if (!if_valid) chk("nop_when_invalid", if_instr, NOP);
        if (pend && !redirect_valid) begin
          chk("req_held", 32'(mem_req), 32'd1);
          chk("addr_held", mem_addr, pend_addr);
        end
        if (mem_req && mem_gnt) begin
          chk("issue_addr", mem_addr, exp_issue);
          exp_issue += 32'd4;
        end
        if (if_valid && first_valid < 0) first_valid = since;
        if (if_valid && !id_stall) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL decode_order: got pc %h with nothing expected", if_pc);
          end else begin
            epc = exp_q.pop_front();
            chk("if_pc", if_pc, epc);
            chk("if_instr", if_instr, mem_word(epc));
            delivered++;
          end
        end
        if (redirect_valid) exp_issue = align(redirect_pc);
      end
      if (rst) begin
        armed = 1'b1;
        exp_issue = RPC;
        first_valid = -1;
      end
      pend = mem_req & ~mem_gnt & ~rst & ~redirect_valid;
      pend_addr = mem_addr;
      prev_rst = rst;
    end
  end

  initial begin
    logic r, rd, st;
    logic [31:0] tgt;

    // Reset, then single-cycle memory with no stalls.
    gnt_pct = 100;
    lat = 1;
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    repeat (20) step(1'b0, 1'b0, '0, 1'b0);
    chk("first_valid_cycle", 32'(first_valid), 32'd3);

    // Decode stall fills the queue and throttles requests.
    repeat (5) step(1'b0, 1'b0, '0, 1'b1);
    chk("stall_req_low", 32'(mem_req), 32'd0);
    repeat (10) step(1'b0, 1'b0, '0, 1'b0);

    // Redirects with responses in flight, misaligned target, PC wrap.
    lat = 3;
    repeat (6) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    repeat (15) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0043, 1'b0);
    repeat (15) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (15) step(1'b0, 1'b0, '0, 1'b0);

    // Reset with a full queue.
    lat = 2;
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    repeat (12) step(1'b0, 1'b0, '0, 1'b0);

    // Randomized traffic.
    gnt_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) lat = $urandom_range(4, 1);
      r  = ($urandom_range(999) < 3);
      rd = !r && (drv_since >= 1) && ($urandom_range(99) < 4);
      case ($urandom_range(2))
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: tgt = $urandom & 32'h3FF;
      endcase
      st = ($urandom_range(99) < 30);
      step(r, rd, tgt, st);
    end
    chk("delivered_enough", 32'(delivered > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
